// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types.
//   word_t     : 32-bit machine word
//   ramstate_t : RAM handshake status (FREE, BUSY, ACCESS, ERROR)
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-request / RAM bus bundle seen by mem_arbiter.
//   icache : iREN, iaddr -> iwait, iload
//   dcache : dREN, dWEN, daddr, dstore -> dwait, dload
//   RAM    : ramREN, ramWEN, ramaddr, ramstore -> ramload, ramstate
// slave  = arbiter view, master = cache/RAM environment view.
interface mem_arbiter_if;
  import cpu_types_pkg::*;
  logic      iREN, iwait;
  word_t     iaddr, iload;
  logic      dREN, dWEN, dwait;
  word_t     daddr, dstore, dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Memory-side arbiter between icache (read-only) and dcache (read/write)
// and a single-ported RAM. Data has priority; after STARVE_LIMIT
// consecutive completed data grants with an instruction fetch pending,
// the next grant goes to the icache.
//   CLK, nRST : clock (rising edge), async active-low reset
//   mif       : cache request and RAM bus (slave view)
// Waits and RAM controls are combinational from state and inputs, so an
// asynchronous reset drops them immediately.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave mif
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, DSERVE, ISERVE} state_t;

  state_t        state, nxt;
  logic [SW-1:0] starve;
  logic          dreq, starved;

  assign dreq    = mif.dREN | mif.dWEN;
  assign starved = mif.iREN && (starve == SW'(STARVE_LIMIT));

  // Read data is broadcast; only the owner's wait qualifies it.
  assign mif.iload = mif.ramload;
  assign mif.dload = mif.ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt          = state;
    mif.iwait    = 1'b1;
    mif.dwait    = 1'b1;
    mif.ramREN   = 1'b0;
    mif.ramWEN   = 1'b0;
    mif.ramaddr  = '0;
    mif.ramstore = '0;
    case (state)
      IDLE: begin
        if (dreq && !starved) nxt = DSERVE;
        else if (mif.iREN)    nxt = ISERVE;
      end
      DSERVE: begin
        if (!dreq) begin
          // Owner withdrew: enables stay low, nothing is committed.
          nxt = IDLE;
        end else begin
          mif.ramaddr  = mif.daddr;
          mif.ramstore = mif.dstore;
          if (mif.dWEN) mif.ramWEN = 1'b1;   // write wins over read
          else          mif.ramREN = 1'b1;
          case (mif.ramstate)
            ACCESS: begin mif.dwait = 1'b0; nxt = IDLE; end
            ERROR:  nxt = IDLE;              // re-arbitrate and retry
            default: ;
          endcase
        end
      end
      ISERVE: begin
        if (!mif.iREN) begin
          nxt = IDLE;
        end else begin
          mif.ramaddr = mif.iaddr;
          mif.ramREN  = 1'b1;
          case (mif.ramstate)
            ACCESS: begin mif.iwait = 1'b0; nxt = IDLE; end
            ERROR:  nxt = IDLE;
            default: ;
          endcase
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Counts completed data grants while a fetch is waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      starve <= '0;
    else if (!mif.iREN)
      starve <= '0;
    else if (state == ISERVE && mif.ramstate == ACCESS)
      starve <= '0;
    else if (state == DSERVE && dreq && mif.ramstate == ACCESS &&
             starve != SW'(STARVE_LIMIT))
      starve <= starve + 1'b1;
  end
endmodule
